// File: rtl/mux4_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_if
//   Bundle between four requesters and the round-robin arbiter that owns the
//   shared 4-to-1 single-bit mux.
//
//   Signals
//     req[3:0]      requester i raises req[i] to ask for the mux
//     D_0..D_3      requester data bits presented to the mux
//     grant[3:0]    one-hot grant, all zero when idle
//     select[1:0]   mux select, index of the granted requester
//     valid         high whenever grant is non-zero
//     D_out         muxed data bit, 0 when not valid
//
//   Modports
//     master  requester side: drives req and data, observes the grant
//     slave   arbiter side: observes req and data, drives the grant
// ---------------------------------------------------------------------------
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic       D_0;
  logic       D_1;
  logic       D_2;
  logic       D_3;
  logic [3:0] grant;
  logic [1:0] select;
  logic       valid;
  logic       D_out;

  modport master (
    output req, D_0, D_1, D_2, D_3,
    input  grant, select, valid, D_out
  );

  modport slave (
    input  req, D_0, D_1, D_2, D_3,
    output grant, select, valid, D_out
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter and sequencer in front of a 4-to-1 single-bit mux.
//   One requester at a time holds the mux for a burst of at most BURST_LEN
//   cycles; the burst ends early when the owner drops its request. Priority
//   rotates to the index after the finishing owner, and a pending requester
//   is granted on the very next cycle with no idle bubble.
//
//   Parameters
//     BURST_LEN   maximum consecutive cycles per grant, 1..16
//
//   Ports
//     clk         rising-edge clock
//     rst         synchronous active-high reset
//     bus         mux4_rr_arbiter_if.slave: req/D_* in, grant/select/valid/D_out out
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mux4_rr_arbiter_if.slave      bus
);

  if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst_len
    $error("mux4_rr_arbiter: BURST_LEN must be in 1..16");
  end

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam logic [3:0] LP_CNT_LAST = 4'(BURST_LEN - 1);

  // First requesting index at or after 'start', wrapping 3 -> 0. Scanning the
  // offsets from far to near lets the nearest hit overwrite the others, so no
  // early exit is needed. With req == 0 the result is unused.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) pick = idx;
    end
  endfunction

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_cnt;
  logic [1:0] r_select;
  logic [3:0] r_grant;
  logic       r_valid;

  logic       w_any_req;
  logic       w_burst_end;
  logic [1:0] w_next_start;
  logic [1:0] w_pick_idle;
  logic [1:0] w_pick_next;
  logic       w_mux;

  assign w_any_req    = |bus.req;
  // Only the owner's request line can end a burst; other req changes are ignored.
  assign w_burst_end  = !bus.req[r_select] || (r_cnt == LP_CNT_LAST);
  // Searching from select+1 visits the current owner last, so it is only
  // regranted when it is the sole requester left.
  assign w_next_start = r_select + 2'd1;
  assign w_pick_idle  = pick(bus.req, r_ptr);
  assign w_pick_next  = pick(bus.req, w_next_start);

  // NOTE: every variable assigned in always_comb gets a value before the case,
  // otherwise an unlisted path would infer a latch.
  always_comb begin
    w_mux = 1'b0;
    case (r_select)
      2'd0:    w_mux = bus.D_0;
      2'd1:    w_mux = bus.D_1;
      2'd2:    w_mux = bus.D_2;
      default: w_mux = bus.D_3;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 2'd0;
      r_cnt    <= 4'd0;
      r_select <= 2'd0;
      r_grant  <= 4'b0000;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_select <= w_pick_idle;
            r_grant  <= 4'b0001 << w_pick_idle;
            r_valid  <= 1'b1;
            r_cnt    <= 4'd0;
            r_state  <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (!w_burst_end) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_ptr <= w_next_start;
            r_cnt <= 4'd0;
            if (w_any_req) begin
              r_select <= w_pick_next;
              r_grant  <= 4'b0001 << w_pick_next;
            end else begin
              // select is left as-is; D_out is gated by valid while idle.
              r_grant <= 4'b0000;
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant  = r_grant;
  assign bus.select = r_select;
  assign bus.valid  = r_valid;
  assign bus.D_out  = r_valid & w_mux;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Directed bench for mux4_rr_arbiter. u_dut uses BURST_LEN = 4 and covers
//   reset, single requester, full rotation, early release, return to idle and
//   reset mid-burst. u_dut1 uses BURST_LEN = 1 for per-cycle rotation.
//   Inputs change 1 ns after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] d_bits;

  int n_tests = 0;
  int n_fail  = 0;

  mux4_rr_arbiter_if bus ();
  mux4_rr_arbiter_if bus1 ();

  assign bus.D_0  = d_bits[0];
  assign bus.D_1  = d_bits[1];
  assign bus.D_2  = d_bits[2];
  assign bus.D_3  = d_bits[3];
  assign bus1.D_0 = d_bits[0];
  assign bus1.D_1 = d_bits[1];
  assign bus1.D_2 = d_bits[2];
  assign bus1.D_3 = d_bits[3];

  mux4_rr_arbiter #(.BURST_LEN(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mux4_rr_arbiter #(.BURST_LEN(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  // Checks all outputs of u_dut against an expected grant; D_out expectation is
  // the data bit of the granted requester, or 0 when no grant.
  task automatic check_out(input string tag, input logic [3:0] exp_grant,
                           input logic [1:0] exp_sel, input bit chk_sel);
    logic exp_dout;
    exp_dout = |(exp_grant & d_bits);
    check({tag, "/grant"}, 32'(bus.grant), 32'(exp_grant));
    check({tag, "/valid"}, 32'(bus.valid), 32'(exp_grant != 4'b0000));
    check({tag, "/dout"},  32'(bus.D_out), 32'(exp_dout));
    if (chk_sel) check({tag, "/select"}, 32'(bus.select), 32'(exp_sel));
  endtask

  task automatic check_out1(input string tag, input logic [3:0] exp_grant, input logic [1:0] exp_sel);
    check({tag, "/grant"},  32'(bus1.grant),  32'(exp_grant));
    check({tag, "/select"}, 32'(bus1.select), 32'(exp_sel));
    check({tag, "/valid"},  32'(bus1.valid),  32'(exp_grant != 4'b0000));
    check({tag, "/dout"},   32'(bus1.D_out),  32'(|(exp_grant & d_bits)));
  endtask

  logic [3:0] rot_grant [5];
  logic [1:0] rot_sel   [5];

  initial begin
    rot_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_sel   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held with every requester asking and every data bit high.
    rst      = 1'b1;
    bus.req  = 4'b1111;
    bus1.req = 4'b1111;
    d_bits   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("reset_hold", 4'b0000, 2'd0, 1'b1);
    end
    rst    = 1'b0;
    d_bits = 4'b0101;

    // Full rotation straight out of reset: 4 cycles per owner, no gaps.
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        check_out($sformatf("rotate_g%0d_c%0d", g, c), rot_grant[g], rot_sel[g], 1'b1);
      end
    end

    // Single requester 2: back-to-back bursts, ptr moves to 3 after the first.
    do_reset();
    bus.req = 4'b0100;
    d_bits  = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_out($sformatf("single_%0d", i), 4'b0100, 2'd2, 1'b1);
      if (i == 3) check("single_ptr_before", 32'(u_dut.r_ptr), 32'd0);
      if (i == 4) begin
        check("single_ptr_after", 32'(u_dut.r_ptr), 32'd3);
        check("single_cnt_regrant", 32'(u_dut.r_cnt), 32'd0);
      end
    end

    // Early release: 1 is granted, drops after 2 cycles, 3 takes over.
    do_reset();
    bus.req = 4'b1010;
    d_bits  = 4'b1000;
    tick();
    check_out("early_c0", 4'b0010, 2'd1, 1'b1);
    tick();
    check_out("early_c1", 4'b0010, 2'd1, 1'b1);
    bus.req = 4'b1000;
    tick();
    check_out("early_handover", 4'b1000, 2'd3, 1'b1);
    check("early_ptr", 32'(u_dut.r_ptr), 32'd2);

    // Return to idle after a full burst on 0, then a fresh request on 2.
    do_reset();
    bus.req = 4'b0001;
    d_bits  = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("idle_burst_%0d", i), 4'b0001, 2'd0, 1'b1);
      if (i == 3) bus.req = 4'b0000;
    end
    tick();
    check_out("idle_after", 4'b0000, 2'd0, 1'b0);
    check("idle_ptr", 32'(u_dut.r_ptr), 32'd1);
    bus.req = 4'b0100;
    tick();
    check_out("idle_regrant", 4'b0100, 2'd2, 1'b1);

    // Reset in the 2nd cycle of a requester-3 burst entered with ptr = 3.
    do_reset();
    bus.req = 4'b0100;
    d_bits  = 4'b1111;
    tick();
    check_out("midrst_pre", 4'b0100, 2'd2, 1'b1);
    bus.req = 4'b1000;
    tick();
    check_out("midrst_c0", 4'b1000, 2'd3, 1'b1);
    check("midrst_ptr_pre", 32'(u_dut.r_ptr), 32'd3);
    tick();
    check_out("midrst_c1", 4'b1000, 2'd3, 1'b1);
    rst = 1'b1;
    tick();
    check_out("midrst_reset", 4'b0000, 2'd0, 1'b1);
    check("midrst_ptr", 32'(u_dut.r_ptr), 32'd0);
    check("midrst_cnt", 32'(u_dut.r_cnt), 32'd0);
    rst     = 1'b0;
    bus.req = 4'b1001;
    tick();
    check_out("midrst_regrant", 4'b0001, 2'd0, 1'b1);

    // BURST_LEN = 1: priority rotates every cycle.
    d_bits   = 4'b0110;
    bus1.req = 4'b1111;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      tick();
      check_out1($sformatf("bl1_rotate_%0d", g), rot_grant[g], rot_sel[g]);
    end
    bus1.req = 4'b0101;
    tick();
    check_out1("bl1_skip_a", 4'b0100, 2'd2);
    tick();
    check_out1("bl1_skip_b", 4'b0001, 2'd0);
    tick();
    check_out1("bl1_skip_c", 4'b0100, 2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares the 4-to-1 single-bit mux datapath between four requesters. Each requester raises a request line. The block grants one requester at a time for a bounded burst, drives the mux select from the registered grant, and rotates priority after every burst. It sits directly in front of the mux, so `select` is always consistent with `grant` and the muxed output.

## Interface

Parameters:
- `BURST_LEN`, default 4: maximum consecutive cycles per grant. Legal range is 1..16.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset. Synchronous and active-high.
- `req`  input  4  request lines; `req[i]` belongs to requester i.
- `D_0`, `D_1`, `D_2`, `D_3`  input  1 each  requester data bits.
- `grant`  output  4  one-hot grant, registered. All zero when idle.
- `select`  output  2  mux select, registered. Equals the index of the granted requester.
- `valid`  output  1  high whenever `grant` is non-zero.
- `D_out`  output  1  muxed data, combinational: `D_out` = `D_select` when `valid` is high, otherwise 0.

## Operation

State:
- `state`: IDLE or GRANT.
- `ptr`: 2-bit priority pointer.
- `cnt`: 4-bit burst counter.
- `select`, `grant`.

Reset values, applied at the rising edge where `rst` = 1:
- state = IDLE, `ptr` = 0, `cnt` = 0.
- `grant` = 4'b0000, `select` = 2'b00, `valid` = 0, `D_out` = 0.

Arbitration function `pick(req, start)`:
- Searches indices start, start+1, start+2, start+3, all mod 4.
- Returns the first index with `req` high.
- The search wraps from 3 back to 0.

IDLE:
- If `req` = 0, stay in IDLE.
- Otherwise, at the next edge: `select` = `pick(req, ptr)`, `grant` is set to match `select`, `cnt` = 0, state goes to GRANT.

GRANT, evaluated every edge:
- The burst ends when `req[select]` = 0, or when `cnt` = `BURST_LEN` − 1.
- If the burst does not end: `cnt` increments and the grant is held.
- If the burst ends:
  - `ptr` = `select` + 1, mod 4.
  - If any `req` bit is high, regrant immediately with no idle cycle: `select` = `pick(req, select+1)`, `cnt` = 0, state stays GRANT.
  - The current requester can be regranted only if it is still requesting and no other requester is. It is reached last in the search order.
  - If `req` = 0, `grant` = 0 and state goes to IDLE.

Edge rules:
- `req` changes on requesters not currently granted never disturb an active burst.
- With `BURST_LEN` = 1, each grant lasts exactly one cycle and priority rotates every cycle.
- `rst` overrides everything at that edge, including mid-burst. No partial state survives.

## Timing

- Request to grant latency: a request sampled at edge n gives `grant`, `select` and `valid` during cycle n+1.
- Burst length: with the request held, `grant` stays high for exactly `BURST_LEN` cycles.
- Handover: with other requesters pending, the next grant is visible in the cycle right after the last burst cycle. There is no bubble.
- Early release: if `req[select]` drops during cycle k, it is sampled at the next edge. Grant ends at that edge, so `grant` stays high through cycle k.
- `D_out` follows the D inputs combinationally in the same cycle, using the registered `select`.
- `grant` is always one-hot or zero. `valid` equals the OR-reduction of `grant`.

## Test plan

1. Reset: hold `rst` = 1 with `req` = 4'b1111 for 3 cycles. Required: `grant` = 0, `select` = 0, `valid` = 0 and `D_out` = 0 throughout. After `rst` is released, the first grant goes to requester 0.
2. Single requester, `BURST_LEN` = 4: hold `req` = 4'b0100 and D_2 = 1.
   - `grant` = 4'b0100 and `select` = 2'b10 continuously, starting one cycle after the request. Bursts regrant back-to-back.
   - `D_out` = 1 while `valid` is high.
   - `ptr` = 3 after the first burst.
3. Full rotation: hold `req` = 4'b1111 from reset with `BURST_LEN` = 4. Required grant sequence, 4 cycles each with no gaps: 0001, 0010, 0100, 1000, 0001.
4. Early release and skip: `req` = 4'b1010 from IDLE with `ptr` = 0.
   - Requester 1 is granted first.
   - Drop `req[1]` after 2 granted cycles. `grant` changes to 4'b1000 on the following cycle, and `ptr` becomes 2.
5. Return to idle: a single burst on requester 0 with all `req` low at the burst end. Required: `grant` = 0 and `valid` = 0 in the next cycle, then a new `req[2]` is granted after 1 cycle.
6. Reset mid-burst: assert `rst` in the 2nd cycle of a requester-3 burst. Required: all outputs are 0 from the next cycle. After release with `req` = 4'b1001, requester 0 is granted because `ptr` was reset to 0.
